block_mem_ctrl: RTL



---
 rtl/block_mem_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/block_mem_ctrl.sv
// rtl/block_mem_ctrl.sv - fixed-latency block main-memory model and controller
//
// Purpose: accepts single-cycle 128-bit block read/write requests from the
// write-back data cache and completes each one LATENCY cycles later with a
// one-cycle mem_ready pulse. A new request may be accepted in the completion
// cycle, so a writeback can be followed directly by its refill read.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   mem_read       block read request (one-cycle pulse)
//   mem_write      block write request (one-cycle pulse)
//   mem_addr       byte address; block index = mem_addr[IDX_BITS+3:4]
//   data_to_mem    write block, sampled in the request cycle
//   data_from_mem  read block, valid in the mem_ready cycle, then held
//   mem_ready      one-cycle completion pulse for reads and writes
//   busy           request outstanding and not yet completing
//   protocol_err   one-cycle pulse after an illegal request
//   rd_count       completed reads  (only with MEM_STATS_EN)
//   wr_count       completed writes (only with MEM_STATS_EN)
//
// Optional feature macro: MEM_STATS_EN adds the completion counters.

module block_mem_ctrl #(
  parameter int LATENCY  = 20,
  parameter int IDX_BITS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_addr,
  input  logic [127:0] data_to_mem,
  output logic [127:0] data_from_mem,
  output logic         mem_ready,
  output logic         busy,
  output logic         protocol_err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int         DEPTH    = 1 << IDX_BITS;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                state;
  logic [7:0]            counter;
  logic [IDX_BITS-1:0]   idx_q;
  logic [127:0]          wdata_q;
  logic [127:0]          mem [DEPTH];

  logic [IDX_BITS-1:0]   req_idx;
  logic                  req_any;
  logic                  accept;
  logic                  completing_wr;
  logic [127:0]          req_rd_data;
  logic                  unused_addr;

  assign req_idx       = mem_addr[IDX_BITS+3:4];
  assign unused_addr   = ^{mem_addr[31:IDX_BITS+4], mem_addr[3:0]};
  assign req_any       = mem_read | mem_write;
  // Accept when idle or in the completion cycle of the previous request.
  assign accept        = req_any && ((state == IDLE) || mem_ready);
  assign completing_wr = (state == WR_WAIT) && mem_ready;

  // With LATENCY=1 a read is loaded onto data_from_mem at its acceptance edge,
  // which can coincide with the commit edge of a completing write; forward the
  // write data so the read sees the new block.
  assign req_rd_data = (completing_wr && (idx_q == req_idx)) ? wdata_q : mem[req_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      data_from_mem <= '0;
      mem_ready     <= 1'b0;
      busy          <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      protocol_err <= (req_any && busy) || (mem_read && mem_write);
      if (accept) begin
        idx_q     <= req_idx;
        wdata_q   <= data_to_mem;
        counter   <= CNT_LOAD;
        state     <= mem_write ? WR_WAIT : RD_WAIT;
        mem_ready <= (LATENCY == 1);
        busy      <= (LATENCY != 1);
        if (!mem_write && (LATENCY == 1)) begin
          data_from_mem <= req_rd_data;
        end
      end else if (state != IDLE) begin
        if (mem_ready) begin
          state     <= IDLE;
          mem_ready <= 1'b0;
        end else begin
          counter <= counter - 8'd1;
          // Counter hits zero on this edge: completion cycle is next.
          if (counter == 8'd1) begin
            mem_ready <= 1'b1;
            busy      <= 1'b0;
            if (state == RD_WAIT) begin
              data_from_mem <= mem[idx_q];
            end
          end
        end
      end
    end
  end

  // Writes commit at the completion edge; a reset beforehand drops them.
  always_ff @(posedge clk) begin
    if (!reset && completing_wr) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (mem_ready) begin
      if (state == RD_WAIT) rd_count <= rd_count + 32'd1;
      if (state == WR_WAIT) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule
